// File: rtl/skinny_sbox_share_feeder_pkg.sv
// Shared constants, FSM state type and share-slicing helper for the Skinny
// S-box share feeder.
package skinny_sbox_pkg;

  localparam int ORDER      = 4;
  localparam int NIBBLE_W   = 4;
  localparam int FRESH_W    = 170;
  localparam int RND_W      = 32;
  localparam int POOL_W     = NIBBLE_W * ORDER + FRESH_W;
  localparam int BEATS      = (POOL_W + RND_W - 1) / RND_W;
  localparam int SHARE_W    = NIBBLE_W * (ORDER + 1);
  localparam int BEAT_CNT_W = $clog2(BEATS);
  // Width of the useful part of the final beat; its upper bits are dropped.
  localparam int LAST_W     = POOL_W - (BEATS - 1) * RND_W;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    IDLE = 2'd1,
    EVAL = 2'd2
  } state_t;

  // Random share idx (1..ORDER) lives in pool nibble idx-1.
  function automatic logic [NIBBLE_W-1:0] share_slice(input logic [POOL_W-1:0] pool,
                                                       input int idx);
    return pool[NIBBLE_W*(idx-1) +: NIBBLE_W];
  endfunction

endpackage

// File: rtl/skinny_sbox_share_feeder_if.sv
// Bundle of the feeder's data, randomness, S-box and status signals.
// Handshakes: a transfer happens at a rising edge where valid && ready; the
// sender keeps its payload stable while valid is high and not yet accepted.
interface skinny_sbox_share_feeder_if;
  import skinny_sbox_pkg::*;

  logic                in_valid;
  logic                in_ready;
  logic [NIBBLE_W-1:0] in_data;
  logic                rnd_valid;
  logic                rnd_ready;
  logic [RND_W-1:0]    rnd_data;
  logic [SHARE_W-1:0]  X_sh;
  logic [FRESH_W-1:0]  Fresh;
  logic                sbox_rst;
  logic                Synch;
  logic                busy;
  logic                done;
  logic                err;
  state_t              dbg_state;

  modport master (
    output in_valid, in_data, rnd_valid, rnd_data, Synch,
    input  in_ready, rnd_ready, X_sh, Fresh, sbox_rst, busy, done, err, dbg_state
  );

  modport slave (
    input  in_valid, in_data, rnd_valid, rnd_data, Synch,
    output in_ready, rnd_ready, X_sh, Fresh, sbox_rst, busy, done, err, dbg_state
  );

endinterface

// File: rtl/skinny_sbox_share_feeder_pool.sv
// Randomness pool: collects BEATS beats in order, flags the completing beat,
// and is wiped by i_clear when its contents are consumed.
module skinny_rnd_pool
  import skinny_sbox_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_beat,
  input  logic [RND_W-1:0]  i_data,
  input  logic              i_clear,
  output logic              o_full,
  output logic [POOL_W-1:0] o_pool
);

  localparam logic [BEAT_CNT_W-1:0] LAST_BEAT = BEAT_CNT_W'(BEATS - 1);

  logic [BEAT_CNT_W-1:0] r_beat_cnt;
  logic [POOL_W-1:0]     r_pool;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_beat_cnt <= '0;
      r_pool     <= '0;
    end else if (i_clear) begin
      r_beat_cnt <= '0;
      r_pool     <= '0;
    end else if (i_beat) begin
      for (int k = 0; k < BEATS - 1; k++) begin
        if (r_beat_cnt == BEAT_CNT_W'(k)) r_pool[k*RND_W +: RND_W] <= i_data;
      end
      if (r_beat_cnt == LAST_BEAT) begin
        r_pool[POOL_W-1 -: LAST_W] <= i_data[LAST_W-1:0];
        r_beat_cnt                 <= '0;
      end else begin
        r_beat_cnt <= r_beat_cnt + 1'b1;
      end
    end
  end

  assign o_full = i_beat && (r_beat_cnt == LAST_BEAT);
  assign o_pool = r_pool;

endmodule

// File: rtl/skinny_sbox_share_feeder.sv
// Masks a nibble into ORDER+1 Boolean shares from a one-shot randomness pool,
// drives the S-box share/Fresh buses and sequences its clock-gating controller.
module skinny_sbox_share_feeder
  import skinny_sbox_pkg::*;
#(
  parameter int WD_LIMIT = 64
) (
  input logic                        clk,
  input logic                        rst,
  skinny_sbox_share_feeder_if.slave  bus
);

  localparam int             WD_W    = $clog2(WD_LIMIT);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(WD_LIMIT - 1);

  state_t              r_state;
  logic [SHARE_W-1:0]  r_x_sh;
  logic [FRESH_W-1:0]  r_fresh;
  logic                r_done;
  logic                r_err;
  logic [WD_W-1:0]     r_wd_cnt;

  logic                w_beat;
  logic                w_accept;
  logic                w_full;
  logic [POOL_W-1:0]   w_pool;
  logic [NIBBLE_W-1:0] w_share0;
  logic [SHARE_W-1:0]  w_x_next;

  assign w_beat   = bus.rnd_valid && (r_state == FILL);
  assign w_accept = bus.in_valid && (r_state == IDLE);

  skinny_rnd_pool u_pool (
    .clk     (clk),
    .rst     (rst),
    .i_beat  (w_beat),
    .i_data  (bus.rnd_data),
    .i_clear (w_accept),
    .o_full  (w_full),
    .o_pool  (w_pool)
  );

  // Share 0 absorbs the secret so that all shares XOR back to in_data.
  always_comb begin
    w_share0 = bus.in_data;
    w_x_next = '0;
    for (int i = 1; i <= ORDER; i++) begin
      w_x_next[NIBBLE_W*i +: NIBBLE_W] = share_slice(w_pool, i);
      w_share0 = w_share0 ^ share_slice(w_pool, i);
    end
    w_x_next[NIBBLE_W-1:0] = w_share0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= FILL;
      r_x_sh   <= '0;
      r_fresh  <= '0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_wd_cnt <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        FILL: begin
          if (w_full) r_state <= IDLE;
        end
        IDLE: begin
          if (bus.in_valid) begin
            r_x_sh   <= w_x_next;
            r_fresh  <= w_pool[POOL_W-1:NIBBLE_W*ORDER];
            r_wd_cnt <= '0;
            r_state  <= EVAL;
          end
        end
        EVAL: begin
          // The controller's Synch is stale in the first cycle after its reset drops.
          if (bus.Synch && (r_wd_cnt != '0)) begin
            r_done  <= 1'b1;
            r_state <= FILL;
          end else if (r_wd_cnt == WD_LAST) begin
            r_err   <= 1'b1;
            r_state <= FILL;
          end else begin
            r_wd_cnt <= r_wd_cnt + 1'b1;
          end
        end
        default: r_state <= FILL;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == IDLE);
  assign bus.rnd_ready = (r_state == FILL);
  assign bus.busy      = (r_state != IDLE);
  assign bus.sbox_rst  = (r_state != EVAL);
  assign bus.X_sh      = r_x_sh;
  assign bus.Fresh     = r_fresh;
  assign bus.done      = r_done;
  assign bus.err       = r_err;
  assign bus.dbg_state = r_state;

endmodule
